type_buffer: RTL
================

Name: type_buffer

Overview:
- Sits between KeyboardDecoder1 and count/vga.
- Turns PS/2 make events into 5-bit character codes and builds the player's typed line.
- Publishes the packed line (type), a per-position correctness mask against the target line, and keystroke/error counters for WPM/accuracy.
- Handles backspace, enter, and a line-full lock.

Parameters:
- MAX_LEN, 25: character slots in the line. Bus widths are 5*MAX_LEN.
- CNT_W, 8: width of the saturating keystroke and error counters.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- enable  input  1  high while in the typing state; key events are ignored when low
- clear  input  1  synchronous clear of line, length, counters and lock
- key_valid  input  1  one-cycle strobe from the decoder
- last_change  input  8  scan code of the latest event
- key_down  input  128  key-held vector from the decoder
- target  input  125  target line, char i at [5i+4:5i]
- type  output  125  typed line, same packing
- len  output  5  number of typed characters, 0..25
- correct  output  25  bit i = 1 iff i < len and type char i == target char i
- key_cnt  output  8  accepted character keystrokes, saturating
- err_cnt  output  8  mismatching keystrokes, saturating
- line_done  output  1  one-cycle pulse when the line completes

Behaviour:
- Character codes: 0 blank; 1..26 = a..z; 27 space.
- Set-2 scan codes:
  - A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A
  - space 29, backspace 66, enter 5A
  - Any other code is ignored.
- Accepted event: key_valid && key_down[last_change[6:0]] && last_change[7]==0 && enable && !locked.
  - Break events (key_down bit low) are ignored.
  - Typematic repeats are accepted as new presses.
- Character press with len < MAX_LEN, all effects at N+1:
  - type slot len <= code
  - len <= len+1
  - key_cnt += 1, saturating at 255
  - err_cnt += 1 (saturating) if code != target slot len
- Backspace with len > 0:
  - slot len-1 <= 0, len <= len-1.
  - Counters are unchanged; errors are never refunded.
  - Backspace at len == 0 is a no-op.
- Line completion and lock:
  - A character press that makes len == MAX_LEN sets locked and pulses line_done at N+1.
  - Enter with len > 0 does the same.
  - Enter at len == 0 is a no-op.
  - While locked, all key events are ignored until clear.
- correct is combinational from the registered type/len and the live target. No extra latency; a target change reflects the same cycle.
- clear (synchronous) clears all slots, len, key_cnt, err_cnt and locked; line_done = 0.
  - clear outranks a key event in the same cycle.
- Reset (rst low, asynchronous): type = 0, len = 0, correct = 0, key_cnt = 0, err_cnt = 0, line_done = 0, locked = 0.
  - Takes effect mid-sequence with no partial write.
- At most one event per cycle; the decoder guarantees strobes are ≥1 cycle apart.

Decomposition:
- Package type_pkg:
  - MAX_LEN, CHAR_W = 5
  - char code constants CH_BLANK, CH_A, CH_SPACE
  - scan-code constants SC_BKSP, SC_ENTER, SC_SPACE
- Sub-module scan_to_char (combinational):
  - last_change -> {is_char, is_bksp, is_enter, code[4:0]}
  - shared later by control for menu hotkeys
- type_buffer holds the registers, lock FSM (OPEN/LOCKED), counters and the correctness compare.

Test Plan:
- Type h,i (33,43) against target "hi..." -> len=2, type[9:0]={9,8}, correct=0x0000003, key_cnt=2, err_cnt=0, each visible one cycle after its strobe.
- Type x (22) against target 'a' at slot 0, then backspace (66), then a (1C) -> len=1, type[4:0]=1, correct bit0=1, key_cnt=2, err_cnt=1.
- 25 character presses -> line_done pulses once at the cycle after the 25th; a 26th press and a backspace are ignored (len stays 25); clear -> len=0, counters 0, keys accepted again.
- Break events, with the key_down bit low for 1C, plus an unmapped code 76 -> no state change; with enable=0, press 1C -> no change.
- clear and a 1C strobe in the same cycle -> len=0, key_cnt=0. Assert rst low mid-line (len=7) -> all outputs 0 immediately, without waiting for clk.
- 300 presses across repeated backspace cycles -> key_cnt saturates at 255 and does not wrap; the same holds for err_cnt with a mismatching target.

Source files
------------

// File: rtl/type_pkg.sv
// Shared definitions for the typing line buffer and its scan-code decoder.
// Holds line geometry, 5-bit character codes, PS/2 set-2 control scan codes
// and the line lock state type.
package type_pkg;

  localparam int unsigned MAX_LEN = 25;
  localparam int unsigned CHAR_W  = 5;
  localparam int unsigned CNT_W   = 8;

  localparam logic [CHAR_W-1:0] CH_BLANK = 5'd0;
  localparam logic [CHAR_W-1:0] CH_A     = 5'd1;
  localparam logic [CHAR_W-1:0] CH_SPACE = 5'd27;

  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic {
    ST_OPEN,
    ST_LOCKED
  } lock_state_e;

endpackage

// File: rtl/type_buffer_scan_to_char.sv
// scan_to_char: combinational PS/2 set-2 scan code classifier.
// Ports:
//   scan     - scan code of the latest event
//   is_char  - scan is a letter or space; code holds its character code
//   is_bksp  - scan is backspace
//   is_enter - scan is enter
//   code     - character code (1..26 = a..z, 27 = space, 0 otherwise)
module scan_to_char
  import type_pkg::*;
(
  input  logic [7:0]        scan,
  output logic              is_char,
  output logic              is_bksp,
  output logic              is_enter,
  output logic [CHAR_W-1:0] code
);

  always_comb begin
    code = CH_BLANK;
    unique case (scan)
      8'h1C: code = 5'd1;   // a
      8'h32: code = 5'd2;   // b
      8'h21: code = 5'd3;   // c
      8'h23: code = 5'd4;   // d
      8'h24: code = 5'd5;   // e
      8'h2B: code = 5'd6;   // f
      8'h34: code = 5'd7;   // g
      8'h33: code = 5'd8;   // h
      8'h43: code = 5'd9;   // i
      8'h3B: code = 5'd10;  // j
      8'h42: code = 5'd11;  // k
      8'h4B: code = 5'd12;  // l
      8'h3A: code = 5'd13;  // m
      8'h31: code = 5'd14;  // n
      8'h44: code = 5'd15;  // o
      8'h4D: code = 5'd16;  // p
      8'h15: code = 5'd17;  // q
      8'h2D: code = 5'd18;  // r
      8'h1B: code = 5'd19;  // s
      8'h2C: code = 5'd20;  // t
      8'h3C: code = 5'd21;  // u
      8'h2A: code = 5'd22;  // v
      8'h1D: code = 5'd23;  // w
      8'h22: code = 5'd24;  // x
      8'h35: code = 5'd25;  // y
      8'h1A: code = 5'd26;  // z
      SC_SPACE: code = CH_SPACE;
      default: code = CH_BLANK;
    endcase
  end

  assign is_char  = (code != CH_BLANK);
  assign is_bksp  = (scan == SC_BKSP);
  assign is_enter = (scan == SC_ENTER);

endmodule

// File: rtl/type_buffer.sv
// type_buffer: builds the player's typed line from PS/2 make events.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   enable        - key events are accepted only while high
//   clear         - synchronous clear of line, length, counters and lock
//   key_valid     - one-cycle event strobe; last_change holds its scan code
//   key_down      - key-held vector, indexed by scan code [6:0]
//   target        - target line, char i at [5i+4:5i]
//   type_line     - typed line, same packing
//   len           - number of typed characters
//   correct       - bit i set when i < len and typed char i matches target
//   key_cnt       - accepted character keystrokes (saturating)
//   err_cnt       - mismatching character keystrokes (saturating)
//   line_done     - one-cycle pulse when the line completes and locks
module type_buffer #(
  parameter int unsigned MAX_LEN = type_pkg::MAX_LEN,
  parameter int unsigned CNT_W   = type_pkg::CNT_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  logic                                clear,
  input  logic                                key_valid,
  input  logic [7:0]                          last_change,
  input  logic [127:0]                        key_down,
  input  logic [type_pkg::CHAR_W*MAX_LEN-1:0] target,
  output logic [type_pkg::CHAR_W*MAX_LEN-1:0] type_line,
  output logic [$clog2(MAX_LEN+1)-1:0]        len,
  output logic [MAX_LEN-1:0]                  correct,
  output logic [CNT_W-1:0]                    key_cnt,
  output logic [CNT_W-1:0]                    err_cnt,
  output logic                                line_done
);
  import type_pkg::*;

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0][CHAR_W-1:0] type_q, type_d;
  logic [MAX_LEN-1:0][CHAR_W-1:0] target_a;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [CNT_W-1:0]               key_cnt_q, key_cnt_d;
  logic [CNT_W-1:0]               err_cnt_q, err_cnt_d;
  logic                           line_done_q, line_done_d;
  lock_state_e                    state_q, state_d;

  logic              is_char, is_bksp, is_enter;
  logic [CHAR_W-1:0] code;
  logic              accept;

  scan_to_char u_scan (
    .scan     (last_change),
    .is_char  (is_char),
    .is_bksp  (is_bksp),
    .is_enter (is_enter),
    .code     (code)
  );

  assign target_a = target;

  // Break events clear the key_down bit, so only make/typematic events pass.
  assign accept = key_valid && key_down[last_change[6:0]] && !last_change[7]
                  && enable && (state_q == ST_OPEN);

  always_comb begin
    type_d      = type_q;
    len_d       = len_q;
    key_cnt_d   = key_cnt_q;
    err_cnt_d   = err_cnt_q;
    state_d     = state_q;
    line_done_d = 1'b0;
    if (clear) begin
      type_d    = '0;
      len_d     = '0;
      key_cnt_d = '0;
      err_cnt_d = '0;
      state_d   = ST_OPEN;
    end else if (accept) begin
      if (is_char && (len_q < LEN_W'(MAX_LEN))) begin
        type_d[len_q] = code;
        len_d         = len_q + 1'b1;
        if (key_cnt_q != '1) key_cnt_d = key_cnt_q + 1'b1;
        if ((code != target_a[len_q]) && (err_cnt_q != '1))
          err_cnt_d = err_cnt_q + 1'b1;
        if (len_q == LEN_W'(MAX_LEN - 1)) begin
          state_d     = ST_LOCKED;
          line_done_d = 1'b1;
        end
      end else if (is_bksp && (len_q != '0)) begin
        type_d[len_q - 1'b1] = CH_BLANK;
        len_d                = len_q - 1'b1;
      end else if (is_enter && (len_q != '0)) begin
        state_d     = ST_LOCKED;
        line_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      type_q      <= '0;
      len_q       <= '0;
      key_cnt_q   <= '0;
      err_cnt_q   <= '0;
      line_done_q <= 1'b0;
      state_q     <= ST_OPEN;
    end else begin
      type_q      <= type_d;
      len_q       <= len_d;
      key_cnt_q   <= key_cnt_d;
      err_cnt_q   <= err_cnt_d;
      line_done_q <= line_done_d;
      state_q     <= state_d;
    end
  end

  // Uses the live target so a target change shows up without a clock edge.
  always_comb begin
    correct = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++)
      correct[i] = (LEN_W'(i) < len_q) && (type_q[i] == target_a[i]);
  end

  assign type_line = type_q;
  assign len       = len_q;
  assign key_cnt   = key_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign line_done = line_done_q;

endmodule
